button_conditioner: RTL
=======================

// Module: button_conditioner
// PURPOSE
//   Input-side counterpart to the display path: turns raw, bouncing, asynchronous push-buttons
//   (start, stop, reset, dev_mode) into clean, clock-synchronous levels and single-cycle events.
//   Sits between the board pins and the FSM / High_Scorer logic.
//   Uses the shared 1 kHz rising-edge tick as its debounce timebase.
// PARAMETERS
//   NUM_BUTTONS    4     number of independent button channels
//   DEBOUNCE_MS    10    ticks the synchronised input must hold a new level before commit (>=1)
//   LONG_PRESS_MS  2000  ticks of committed-high hold before long_press fires (> DEBOUNCE_MS)
//   CNT_W          12    counter width; must hold LONG_PRESS_MS
// PORTS
//   clock             in   1            system clock (CLK100MHZ domain); single clock
//   reset             in   1            synchronous, active-high
//   rising_edge_1khz  in   1            one-clock tick, 1 kHz
//   buttons_raw       in   NUM_BUTTONS  raw pin levels, asynchronous, 1 = pressed
//   buttons_level     out  NUM_BUTTONS  debounced level per channel
//   press_pulse       out  NUM_BUTTONS  1-clock pulse on committed 0->1
//   release_pulse     out  NUM_BUTTONS  1-clock pulse on committed 1->0
//   long_press_pulse  out  NUM_BUTTONS  1-clock pulse when a hold reaches LONG_PRESS_MS
// BEHAVIOUR
//   - Reset: all outputs 0; synchroniser flops 0; every channel in S_LOW; all counters 0.
//   - Sync: 2-flop synchroniser per channel; sync = 2nd flop. All channels are fully independent.
//   - Channel FSM:
//     - S_LOW: sync=1 -> S_PEND_HI, dcnt=0.
//     - S_PEND_HI: sync=0 -> S_LOW, dcnt=0 (glitch rejected, no pulse).
//       Else on tick dcnt++; on the tick where dcnt reaches DEBOUNCE_MS -> S_HIGH,
//       level<=1, press_pulse<=1 for one clock, hcnt=0.
//     - S_HIGH: on tick hcnt++ (saturating); when hcnt reaches LONG_PRESS_MS,
//       long_press_pulse<=1 once per hold.
//       sync=0 -> S_PEND_LO, dcnt=0; hcnt keeps its value, no further long pulse while pending.
//     - S_PEND_LO: sync=1 -> S_HIGH, dcnt=0, hold continues.
//       Else on tick dcnt++; at DEBOUNCE_MS -> S_LOW, level<=0, release_pulse<=1, hcnt=0.
//   - Latency: raw edge -> pulse = 2 clocks sync + DEBOUNCE_MS ticks + 1 registered clock.
//     The first tick may be partial, so debounce time is (DEBOUNCE_MS-1, DEBOUNCE_MS] ms.
//   - All outputs are registered. press/release/long pulses are exactly 1 clock wide.
//     press and release never assert together on one channel.
//     long_press may coincide with neither press nor release.
//   - Sync change and tick in the same clock: the level change wins, dcnt clears, the tick is discarded.
//   - Reset mid-operation: outputs drop to 0 next edge without a release_pulse.
//     A button still held after reset must re-debounce and produces a fresh press_pulse.
//   - Tick held low: counters freeze and no commits occur. Levels stay put.
//   - Counters saturate and never wrap.
// STRUCTURE
//   - Shared defines header: `BTN_START=0, `BTN_STOP=1, `BTN_RESET=2, `BTN_DEV=3 channel indices.
//   - Shared defines header: channel state encodings `BTN_S_LOW/PEND_HI/HIGH/PEND_LO (2 bits).
//   - Sub-module button_debounce_channel: one channel (sync + FSM + dcnt/hcnt).
//     It is instantiated NUM_BUTTONS times via generate. The top level is wiring only.
// TESTING (bench drives tick every 4 clocks; DEBOUNCE_MS=10, LONG_PRESS_MS=50)
//   1. Reset held 5 clocks with buttons_raw=4'hF:
//      all outputs 0; after release, each channel press_pulse once, 2+10 ticks+1 clocks later.
//   2. ch0 bounce: 1 for 3 ticks, 0 for 1 tick, then 1 steady:
//      no pulse until 10 full ticks after the last rise, then one press_pulse, level=1.
//   3. ch1 held 60 ticks then released:
//      press, then long_press_pulse exactly once at hold tick 50, then release 10 ticks after drop.
//   4. ch2 pressed, 5-tick dropout while high:
//      no release, level stays 1, no second press_pulse.
//   5. ch0 and ch3 pressed in the same clock: identical simultaneous press_pulses, other channels 0.
//   6. Reset asserted while ch1 level=1:
//      level->0 with no release_pulse; raw still 1 -> new press_pulse after debounce.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared channel indices and per-channel state encoding for the button input path.
package button_conditioner_pkg;

  localparam int BTN_COUNT = 4;

  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_RESET = 2;
  localparam int BTN_DEV   = 3;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_PEND_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_PEND_LO = 2'd3
  } btn_state_e;

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: 2-flop synchroniser, tick-based debounce FSM, long-press hold counter.
module button_debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_MS   = 10,
  parameter int LONG_PRESS_MS = 2000,
  parameter int CNT_W         = 12
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_PRESS_MS);

  logic             meta_q, sync_q;
  btn_state_e       state_q;
  logic [CNT_W-1:0] dcnt_q, hcnt_q;
  logic             level_q, press_q, release_q, long_q;

  // A sync change always takes priority over a tick in the same clock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      state_q   <= S_LOW;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      meta_q    <= raw_i;
      sync_q    <= meta_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      unique case (state_q)
        S_LOW: begin
          if (sync_q) begin
            state_q <= S_PEND_HI;
            dcnt_q  <= '0;
          end
        end
        S_PEND_HI: begin
          if (!sync_q) begin
            state_q <= S_LOW;
            dcnt_q  <= '0;
          end else if (tick_i) begin
            if (dcnt_q == DEB_LAST) begin
              state_q <= S_HIGH;
              level_q <= 1'b1;
              press_q <= 1'b1;
              hcnt_q  <= '0;
              dcnt_q  <= '0;
            end else begin
              dcnt_q <= dcnt_q + ONE;
            end
          end
        end
        S_HIGH: begin
          if (!sync_q) begin
            state_q <= S_PEND_LO;
            dcnt_q  <= '0;
          end else if (tick_i && hcnt_q != LONG_MAX) begin
            // Saturating at LONG_MAX makes the equality fire only once per hold.
            hcnt_q <= hcnt_q + ONE;
            if (hcnt_q == LONG_MAX - ONE) long_q <= 1'b1;
          end
        end
        S_PEND_LO: begin
          if (sync_q) begin
            state_q <= S_HIGH;
            dcnt_q  <= '0;
          end else if (tick_i) begin
            if (dcnt_q == DEB_LAST) begin
              state_q   <= S_LOW;
              level_q   <= 1'b0;
              release_q <= 1'b1;
              hcnt_q    <= '0;
              dcnt_q    <= '0;
            end else begin
              dcnt_q <= dcnt_q + ONE;
            end
          end
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces NUM_BUTTONS raw push-buttons into clean levels and single-clock events.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BUTTONS   = BTN_COUNT,
  parameter int DEBOUNCE_MS   = 10,
  parameter int LONG_PRESS_MS = 2000,
  parameter int CNT_W         = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rising_edge_1khz,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  output logic [NUM_BUTTONS-1:0] buttons_level,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] long_press_pulse
);

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    button_debounce_channel #(
      .DEBOUNCE_MS  (DEBOUNCE_MS),
      .LONG_PRESS_MS(LONG_PRESS_MS),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk_i    (clock),
      .rst_i    (reset),
      .tick_i   (rising_edge_1khz),
      .raw_i    (buttons_raw[g]),
      .level_o  (buttons_level[g]),
      .press_o  (press_pulse[g]),
      .release_o(release_pulse[g]),
      .long_o   (long_press_pulse[g])
    );
  end

endmodule
